udp_tx_sched: RTL and testbench

- Round-robin scheduler that shares one udp_send transmitter between two payload sources (ch0, ch1).
- Issues the start pulse and latches the byte count for the granted channel.
- Steers the transmitter's tx_req/tx_data handshake to that channel and reports completion per channel.
- Enforces an inter-packet gap and a watchdog so a stalled transmitter cannot lock out both channels.

---
 rtl/udp_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/udp_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_udp_tx_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
package udp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_START     = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_GAP       = 4'b1000
  } sched_state_e;

  localparam logic [15:0] ETH_MIN_PAYLOAD    = 16'd18;
  localparam logic [15:0] DEF_GAP_CYCLES     = 16'd12;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd4096;

  // Saturating increment keeps the cycle counters from wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// channel that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Pick the winner from the request pair and the previous winner.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Shares one udp_send transmitter between two payload channels with
// round-robin arbitration, an inter-packet gap and a completion watchdog.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrate; zero-length winners are acknowledged here
// START     | single-cycle tx_start_en with the latched byte count
// WAIT_DONE | handshake steered to the granted channel, watchdog running
// GAP       | enforced quiet time, requests and transmitter ignored
module udp_tx_sched
  import udp_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [31:0] ch0_data,
  output logic        ch0_grant,
  output logic        ch0_rd_en,
  output logic        ch0_done,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [31:0] ch1_data,
  output logic        ch1_grant,
  output logic        ch1_rd_en,
  output logic        ch1_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic        timeout_err
);

  sched_state_e state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   done_q, done_d;
  logic         start_q, start_d;
  logic [15:0]  bytes_q, bytes_d;
  logic         terr_q, terr_d;
  logic         last_q, last_d;
  logic [15:0]  wd_q, wd_d;
  logic [15:0]  gap_q, gap_d;

  logic         arb_valid;
  logic         arb_winner;
  logic [15:0]  win_bytes;

  rr_arb2 u_arb (
    .req        ({ch1_req, ch0_req}),
    .last_grant (last_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign win_bytes = arb_winner ? ch1_byte_num : ch0_byte_num;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    start_d = 1'b0;
    bytes_d = bytes_q;
    terr_d  = 1'b0;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          last_d = arb_winner;
          if (win_bytes == 16'd0) begin
            done_d[arb_winner] = 1'b1;
          end else begin
            state_d = ST_START;
            grant_d = arb_winner ? 2'b10 : 2'b01;
            start_d = 1'b1;
            bytes_d = win_bytes;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
        wd_d    = 16'd0;
      end
      ST_WAIT_DONE: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (tx_done) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          state_d = ST_GAP;
          gap_d   = 16'd0;
        end else if (wd_q == TIMEOUT_CYCLES - 16'd1) begin
          terr_d  = 1'b1;
          done_d  = grant_q;
          grant_d = 2'b00;
          state_d = ST_GAP;
          gap_d   = 16'd0;
        end else begin
          wd_d = sat_inc(wd_q);
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_CYCLES - 16'd1) state_d = ST_IDLE;
        else                             gap_d   = sat_inc(gap_q);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and registered outputs; reset abandons any packet without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      bytes_q <= 16'd0;
      terr_q  <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= 16'd0;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      start_q <= start_d;
      bytes_q <= bytes_d;
      terr_q  <= terr_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  // Handshake steering toward the owning channel.
  always_comb begin
    ch0_rd_en = tx_req & grant_q[0] & (state_q == ST_WAIT_DONE);
    ch1_rd_en = tx_req & grant_q[1] & (state_q == ST_WAIT_DONE);
    if (grant_q[0])      tx_data = ch0_data;
    else if (grant_q[1]) tx_data = ch1_data;
    else                 tx_data = 32'd0;
  end

  assign ch0_grant   = grant_q[0];
  assign ch1_grant   = grant_q[1];
  assign ch0_done    = done_q[0];
  assign ch1_done    = done_q[1];
  assign tx_start_en = start_q;
  assign tx_byte_num = bytes_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched: directed scenarios followed by
// randomized request rounds predicted by a pending-set round-robin model.
module tb_udp_tx_sched;

  localparam int GAP = 12;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] bn [2];
  logic [31:0] dat [2];
  logic        tx_req, tx_done;
  logic        ch0_grant, ch1_grant, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done;
  logic        tx_start_en, busy, timeout_err;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;

  wire [1:0] grant = {ch1_grant, ch0_grant};
  wire [1:0] rd_en = {ch1_rd_en, ch0_rd_en};
  wire [1:0] done  = {ch1_done, ch0_done};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1000;
  int start_cyc = 0;
  int last_exp = 1;
  bit mon_en = 1'b0;
  logic prev_start;

  udp_tx_sched #(.GAP_CYCLES(16'd12), .TIMEOUT_CYCLES(16'd16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch0_req      (req[0]),
    .ch0_byte_num (bn[0]),
    .ch0_data     (dat[0]),
    .ch0_grant    (ch0_grant),
    .ch0_rd_en    (ch0_rd_en),
    .ch0_done     (ch0_done),
    .ch1_req      (req[1]),
    .ch1_byte_num (bn[1]),
    .ch1_data     (dat[1]),
    .ch1_grant    (ch1_grant),
    .ch1_rd_en    (ch1_rd_en),
    .ch1_done     (ch1_done),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle-level invariants that must hold at every sample point.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("one_grant", {31'd0, ch0_grant & ch1_grant}, 32'd0);
      chk("start_twice", {31'd0, tx_start_en & prev_start}, 32'd0);
      chk("rd_en_wo_grant", {30'd0, rd_en & ~grant}, 32'd0);
      chk("tx_data_mux", tx_data, ch0_grant ? dat[0] : (ch1_grant ? dat[1] : 32'd0));
    end
    prev_start <= tx_start_en;
  end

  // Serve one arbitration decision. Entered at a negedge with the DUT idle
  // and requests applied; w = WAIT cycles before tx_done, -1 = never.
  task automatic serve(input int ch, input int w);
    logic [15:0] b;
    logic [31:0] m;
    int n;
    b = bn[ch];
    m = 32'd1 << ch;
    @(negedge clk);
    if (b == 16'd0) begin
      chk("zl_done", {30'd0, done}, m);
      chk("zl_start", {31'd0, tx_start_en}, 32'd0);
      chk("zl_busy", {31'd0, busy}, 32'd0);
      chk("zl_grant", {30'd0, grant}, 32'd0);
      req[ch] = 1'b0;
      last_exp = ch;
      return;
    end
    chk("grant", {30'd0, grant}, m);
    chk("start", {31'd0, tx_start_en}, 32'd1);
    chk("byte_num", {16'd0, tx_byte_num}, {16'd0, b});
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("gap_min", {31'd0, (cyc - done_cyc) >= GAP + 2}, 32'd1);
    start_cyc = cyc;
    @(negedge clk);
    chk("start_width", {31'd0, tx_start_en}, 32'd0);
    n = (w < 0) ? TO : w;
    for (int i = 0; i < n; i++) begin
      chk("early_done", {30'd0, done}, 32'd0);
      tx_req = 1'($urandom_range(0, 1));
      dat[0] = $urandom;
      dat[1] = $urandom;
      #1;
      chk("rd_en", {30'd0, rd_en}, tx_req ? m : 32'd0);
      chk("tx_data", tx_data, dat[ch]);
      @(negedge clk);
    end
    tx_req = 1'b0;
    if (w >= 0) begin
      tx_done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      tx_done = 1'b0;
    end else begin
      done_cyc = cyc - 1;
      chk("wd_latency", cyc - start_cyc, 32'd17);
    end
    chk("done", {30'd0, done}, m);
    chk("grant_off", {30'd0, grant}, 32'd0);
    chk("timeout_err", {31'd0, timeout_err}, (w < 0) ? 32'd1 : 32'd0);
    chk("busy_gap", {31'd0, busy}, 32'd1);
    req[ch] = 1'b0;
    last_exp = ch;
    for (int i = 0; i < GAP - 1; i++) begin
      tx_req  = 1'($urandom_range(0, 1));
      tx_done = 1'($urandom_range(0, 1));
      #1;
      chk("gap_rd_en", {30'd0, rd_en}, 32'd0);
      @(negedge clk);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      chk("gap_done", {30'd0, done}, 32'd0);
      chk("gap_terr", {31'd0, timeout_err}, 32'd0);
    end
    tx_req  = 1'b0;
    tx_done = 1'b0;
    @(negedge clk);
    chk("gap_end_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int win;
    int w;
    rst_n = 1'b0; req = 2'b00; tx_req = 1'b0; tx_done = 1'b0;
    bn[0] = 16'd0; bn[1] = 16'd0; dat[0] = 32'd0; dat[1] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_start", {31'd0, tx_start_en}, 32'd0);
    chk("rst_bytes", {16'd0, tx_byte_num}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Single ch0 request, 64 bytes.
    bn[0] = 16'd64; req[0] = 1'b1;
    serve(0, 5);

    // Watchdog on ch1: tx_done never arrives.
    bn[1] = 16'd100; req[1] = 1'b1;
    serve(1, -1);

    // Contention: both held, winners must alternate starting with ch0.
    bn[0] = 16'd20; bn[1] = 16'd30; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 1 - last_exp, k % 2);
      serve(1 - last_exp, 3);
      req = 2'b11;
    end
    req = 2'b00;

    // tx_done on the watchdog expiry cycle.
    bn[0] = 16'd77; req[0] = 1'b1;
    serve(0, TO - 1);

    // Zero-length ch0 packet.
    bn[0] = 16'd0; req[0] = 1'b1;
    serve(0, 0);
    @(negedge clk);
    chk("zl_idle", {31'd0, busy}, 32'd0);
    chk("zl_no_repeat", {30'd0, done}, 32'd0);

    // Reset during WAIT_DONE, then spurious tx_done while idle.
    bn[0] = 16'd40; req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", {30'd0, grant}, 32'd0);
    chk("mid_rst_done", {30'd0, done}, 32'd0);
    chk("mid_rst_start", {31'd0, tx_start_en}, 32'd0);
    chk("mid_rst_bytes", {16'd0, tx_byte_num}, 32'd0);
    chk("mid_rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1; req[0] = 1'b0; tx_done = 1'b1;
    last_exp = 1; done_cyc = -1000;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_done", {30'd0, done}, 32'd0);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("post_rst_done", {30'd0, done}, 32'd0);
    bn[1] = 16'd500; req[1] = 1'b1;
    serve(1, 4);

    // Randomized rounds against the pending-set round-robin model.
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req[c] && $urandom_range(0, 2) != 0) begin
          bn[c] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
          req[c] = 1'b1;
        end
      end
      if (req == 2'b00) begin
        bn[0] = 16'($urandom_range(1, 1500));
        req[0] = 1'b1;
      end
      win = (req == 2'b11) ? 1 - last_exp : (req[1] ? 1 : 0);
      w = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      serve(win, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
